// File: rtl/bar_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package     : bar_pkg                                            |
// | Description : Shared widths, error code, FSM encoding and the    |
// |               thermometer-to-binary decode for the switch bar.   |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
package bar_pkg;

    localparam int BAR_W = 10;
    localparam int BIN_W = 4;
    localparam logic [BIN_W-1:0] ERR_CODE = 4'hF;

    // Single-hot encoding of the commit tracker.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SETTLE = 3'b010,
        ST_COMMIT = 3'b100
    } bar_state_e;

    // Returns {err, value}. Legal patterns are the 11 thermometer codes
    // (1<<k)-1 for k = 0..BAR_W; anything else decodes to {1, ERR_CODE}.
    function automatic logic [BIN_W:0] therm2bin(input logic [BAR_W-1:0] pattern);
        logic [BIN_W:0] res;
        res = {1'b1, ERR_CODE};
        for (int k = 0; k <= BAR_W; k++) begin
            if ({1'b0, pattern} == (((BAR_W+1)'(1) << k) - (BAR_W+1)'(1))) begin
                res = {1'b0, BIN_W'(k)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_debounce.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sync_debounce                                      |
// | Description : Two-flop synchroniser followed by a saturating     |
// |               stability counter. Emits the accepted pattern and  |
// |               a one-cycle strobe the first time it is stable.    |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module sync_debounce
    import bar_pkg::*;
#(
    parameter int WIDTH           = BAR_W,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cand,
    output logic             changing,
    output logic [WIDTH-1:0] stable,
    output logic             new_stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fired_q, fired_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic             new_stable_q, new_stable_d;

    // Next-state for synchroniser, candidate tracking and the stability counter.
    always_comb begin
        s1_d         = din;
        s2_d         = s1_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        fired_d      = fired_q;
        stable_d     = stable_q;
        new_stable_d = 1'b0;

        // First cycle at saturation: publish the candidate once.
        if (cnt_q == CNT_MAX && !fired_q) begin
            new_stable_d = 1'b1;
            stable_d     = cand_q;
            fired_d      = 1'b1;
        end

        // A differing sample restarts the count; it must override the
        // fired flag so the new candidate can strobe later.
        if (s2_q != cand_q) begin
            cand_d  = s2_q;
            cnt_d   = '0;
            fired_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset clears the whole pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q         <= '0;
            s2_q         <= '0;
            cand_q       <= '0;
            cnt_q        <= '0;
            fired_q      <= 1'b0;
            stable_q     <= '0;
            new_stable_q <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            fired_q      <= fired_d;
            stable_q     <= stable_d;
            new_stable_q <= new_stable_d;
        end
    end

    assign cand       = cand_q;
    assign changing   = (s2_q != cand_q);
    assign stable     = stable_q;
    assign new_stable = new_stable_q;

endmodule
`default_nettype wire

// File: rtl/bar_2_bin.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : bar_2_bin                                          |
// | Description : Debounced 10-switch thermometer bar to 4-bit count |
// |               with valid/ready event output, continuous level    |
// |               and sticky overrun flag.                           |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module bar_2_bin
    import bar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BAR_W-1:0] sw,
    output logic [BIN_W-1:0] out_value,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIN_W-1:0] level,
    output logic             level_err,
    output logic             overrun
);

    logic [BAR_W-1:0] cand_w;
    logic             changing_w;
    logic [BAR_W-1:0] stable_w;
    logic             new_stable_w;
    logic [BIN_W:0]   dec_w;
    logic             commit_w;

    bar_state_e       state_q, state_d;
    logic [BAR_W-1:0] committed_q, committed_d;
    logic [BIN_W-1:0] level_q, level_d;
    logic             level_err_q, level_err_d;
    logic [BIN_W-1:0] out_value_q, out_value_d;
    logic             out_err_q, out_err_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    sync_debounce #(
        .WIDTH           (BAR_W),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk        (clk),
        .rst        (rst),
        .din        (sw),
        .cand       (cand_w),
        .changing   (changing_w),
        .stable     (stable_w),
        .new_stable (new_stable_w)
    );

    assign dec_w = therm2bin(stable_w);

    // A newly stable pattern is only an event if it differs from the
    // committed one; returning to the committed value is silent.
    assign commit_w = new_stable_w && (stable_w != committed_q) && (state_q == ST_SETTLE);

    // Tracker: SETTLE whenever the candidate disagrees with the committed pattern.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (changing_w || (cand_w != committed_q)) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (commit_w)                                      state_d = ST_COMMIT;
                else if (!changing_w && (cand_w == committed_q))   state_d = ST_IDLE;
            end
            ST_COMMIT: begin
                if (changing_w || (cand_w != committed_q)) state_d = ST_SETTLE;
                else                                       state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Commit, level update and valid/ready handshake with overrun detection.
    always_comb begin
        committed_d = committed_q;
        level_d     = level_q;
        level_err_d = level_err_q;
        out_value_d = out_value_q;
        out_err_d   = out_err_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (commit_w) begin
            committed_d = stable_w;
            level_d     = dec_w[BIN_W-1:0];
            level_err_d = dec_w[BIN_W];
            out_value_d = dec_w[BIN_W-1:0];
            out_err_d   = dec_w[BIN_W];
            out_valid_d = 1'b1;
            // Latest event wins; losing an unaccepted one is remembered.
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Registers for tracker state and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            committed_q <= '0;
            level_q     <= '0;
            level_err_q <= 1'b0;
            out_value_q <= '0;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            committed_q <= committed_d;
            level_q     <= level_d;
            level_err_q <= level_err_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_value = out_value_q;
    assign out_err   = out_err_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;
    assign level_err = level_err_q;
    assign overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_bar_2_bin.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_bar_2_bin                                       |
// | Description : Scoreboard bench for bar_2_bin: directed switch    |
// |               patterns, expected events queued, monitor compares |
// |               on every accepted handshake.                       |
// | Revision    : 1.0                                                |
// +------------------------------------------------------------------+
module tb_bar_2_bin;
    import bar_pkg::*;

    localparam int DEB = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [BAR_W-1:0] sw;
    logic             out_ready;
    logic [BIN_W-1:0] out_value;
    logic             out_err;
    logic             out_valid;
    logic [BIN_W-1:0] level;
    logic             level_err;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    // Expected events as {err, value}.
    logic [4:0] exp_q[$];

    bar_2_bin #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .out_value (out_value),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .level_err (level_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected event.
    initial begin
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_event actual=%0h required=none", {out_err, out_value});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_err, out_value} !== e) begin
                        failures++;
                        $display("FAIL event_payload actual=%0h required=%0h", {out_err, out_value}, e);
                    end
                end
            end
        end
    end

    initial begin
        logic seen;
        rst       = 1'b1;
        sw        = '0;
        out_ready = 1'b0;

        // Reset state.
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;

        // Power-up with all switches off: no event.
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (out_valid) seen = 1'b1;
        end
        check("idle_no_event", seen, 0);
        check("idle_level", level, 0);
        check("idle_overrun", overrun, 0);

        // Basic latency: sampled at edge t, valid after edge t+19.
        out_ready = 1'b1;
        sw        = 10'h007;
        exp_q.push_back({1'b0, 4'd3});
        tick(19);
        check("lat_early", out_valid, 0);
        tick(1);
        check("lat_valid", out_valid, 1);
        check("lat_value", out_value, 3);
        check("lat_err", out_err, 0);
        check("lat_level", level, 3);
        tick(1);
        check("lat_pulse_end", out_valid, 0);

        // Bounce between full and empty, then settle full: one event only.
        exp_q.push_back({1'b0, 4'hA});
        for (int i = 0; i < 8; i++) begin
            sw = (i % 2 == 0) ? 10'h3FF : 10'h000;
            tick(5);
        end
        sw = 10'h3FF;
        tick(40);
        check("bounce_level", level, 4'hA);
        check("bounce_level_err", level_err, 0);

        // Non-thermometer pattern.
        sw = 10'h155;
        exp_q.push_back({1'b1, 4'hF});
        tick(40);
        check("bad_level", level, 4'hF);
        check("bad_level_err", level_err, 1);

        // Overwrite while not ready: latest wins, overrun sticky.
        out_ready = 1'b0;
        sw        = 10'h007;
        tick(30);
        check("ovr_valid1", out_valid, 1);
        check("ovr_value1", out_value, 3);
        check("ovr_flag1", overrun, 0);
        sw = 10'h01F;
        exp_q.push_back({1'b0, 4'd5});
        tick(30);
        check("ovr_valid2", out_valid, 1);
        check("ovr_value2", out_value, 5);
        check("ovr_err2", out_err, 0);
        check("ovr_flag2", overrun, 1);
        check("ovr_level", level, 5);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        check("ovr_accept_clear", out_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Reset mid-debounce (counter at 8), then full debounce after release.
        out_ready = 1'b1;
        sw        = 10'h0FF;
        tick(11);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_value", out_value, 0);
        check("mid_rst_level", level, 0);
        check("mid_rst_overrun", overrun, 0);
        tick(2);
        rst = 1'b0;
        exp_q.push_back({1'b0, 4'd8});
        tick(19);
        check("post_rst_early", out_valid, 0);
        tick(1);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_value", out_value, 8);
        check("post_rst_level", level, 8);
        tick(3);
        check("post_rst_clear", out_valid, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
